// File: rtl/lnvd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lnvd_pkg
// Description : Shared constants and types for the lnvd sample delay path:
//               sample geometry (4 channels x 12 bits), ring geometry, FSM
//               state encoding and output-source selector.
// Revision    : 1.0 - initial release
// ============================================================================
package lnvd_pkg;

    localparam int SAMPLE_W   = 12;
    localparam int N_CH       = 4;
    localparam int LNVD_DEPTH = 256;
    localparam int LNVD_AW    = 8;
    localparam int LNVD_DW    = SAMPLE_W * N_CH;
    localparam int DROP_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Which register currently feeds data_out.
    typedef enum logic [1:0] {
        OUT_ZERO = 2'd0,
        OUT_RAM  = 2'd1,
        OUT_BYP  = 2'd2
    } out_src_e;

endpackage : lnvd_pkg
`default_nettype wire

// File: rtl/lnvd_delay_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : lnvd_delay_sched_if
// Description : Stream, configuration and status bundle of lnvd_delay_sched.
//               slave  : the delay scheduler side
//               master : the producer / controller side
//               Ports : s_valid, data_in, cfg_delay, cfg_load, start, stop
//                       (to scheduler); m_valid, data_out, busy, state,
//                       cfg_err (from scheduler); drop_cnt when
//                       LNVD_DELAY_DROP_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface lnvd_delay_sched_if #(
    parameter int AW = lnvd_pkg::LNVD_AW,
    parameter int DW = lnvd_pkg::LNVD_DW
);
    logic          s_valid;
    logic [DW-1:0] data_in;
    logic [AW:0]   cfg_delay;
    logic          cfg_load;
    logic          start;
    logic          stop;
    logic          m_valid;
    logic [DW-1:0] data_out;
    logic          busy;
    logic [1:0]    state;
    logic          cfg_err;
`ifdef LNVD_DELAY_DROP_CNT_EN
    logic [lnvd_pkg::DROP_W-1:0] drop_cnt;
`endif

    modport slave (
        input  s_valid, data_in, cfg_delay, cfg_load, start, stop,
        output m_valid, data_out, busy, state, cfg_err
`ifdef LNVD_DELAY_DROP_CNT_EN
        , output drop_cnt
`endif
    );

    modport master (
        output s_valid, data_in, cfg_delay, cfg_load, start, stop,
        input  m_valid, data_out, busy, state, cfg_err
`ifdef LNVD_DELAY_DROP_CNT_EN
        , input drop_cnt
`endif
    );

endinterface : lnvd_delay_sched_if
`default_nettype wire

// File: rtl/lnvd_ring_ram.sv
`default_nettype none
// ============================================================================
// Module      : lnvd_ring_ram
// Description : DEPTH x DW simple dual-port RAM, synchronous write and
//               synchronous read-before-write (a read of the address being
//               written returns the old entry). Read data holds until the
//               next read enable. No reset, so it maps onto block RAM.
//               Ports : clk, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data
// Revision    : 1.0 - initial release
// ============================================================================
module lnvd_ring_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 48
) (
    input  wire logic          clk,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [DW-1:0] wr_data,
    input  wire logic          rd_en,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    // Both ports in one process with non-blocking writes: the read samples
    // mem before this edge's write lands.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule : lnvd_ring_ram
`default_nettype wire

// File: rtl/lnvd_delay_sched.sv
`default_nettype none
// ============================================================================
// Module      : lnvd_delay_sched
// Description : Programmable whole-sample delay for packed 4 x 12-bit
//               samples. IDLE/FILL/RUN/FLUSH sequencer over a ring buffer;
//               FILL primes delay_reg entries so no stale entry is read.
//               Ports : clk, rst (async, active high), bus (slave modport)
//               Option: LNVD_DELAY_DROP_CNT_EN adds bus.drop_cnt, a
//                       saturating count of samples dropped in IDLE/FLUSH
//                       or together with stop; cleared on start.
// Revision    : 1.0 - initial release
// ============================================================================
module lnvd_delay_sched
    import lnvd_pkg::*;
#(
    parameter int DEPTH = LNVD_DEPTH,
    parameter int AW    = LNVD_AW,
    parameter int DW    = LNVD_DW
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lnvd_delay_sched_if.slave  bus
);

    state_e        state_q,    state_d;
    out_src_e      src_q,      src_d;
    logic [AW-1:0] delay_q,    delay_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    logic [DW-1:0] byp_q,      byp_d;
    logic          m_valid_q,  m_valid_d;
    logic          cfg_err_q,  cfg_err_d;

    logic          ram_wr_en;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          cfg_too_big;

    assign cfg_too_big = bus.cfg_delay > (AW+1)'(DEPTH-1);
    assign ram_rd_addr = wr_ptr_q - delay_q;   // wraps mod DEPTH

    lnvd_ring_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ring (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        delay_d    = delay_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        byp_d      = byp_q;
        m_valid_d  = 1'b0;
        cfg_err_d  = 1'b0;
        ram_wr_en  = 1'b0;
        ram_rd_en  = 1'b0;

        if (bus.cfg_load) begin
            if (state_q == ST_IDLE) begin
                delay_d   = cfg_too_big ? AW'(DEPTH-1) : bus.cfg_delay[AW-1:0];
                cfg_err_d = cfg_too_big;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        // stop wins over everything in FILL/RUN; the coincident sample is dropped.
        if (bus.stop && (state_q == ST_FILL || state_q == ST_RUN)) begin
            state_d = ST_FLUSH;
            src_d   = OUT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // delay_d so that a same-cycle cfg_load picks the right path.
                    if (bus.start && !bus.stop) begin
                        state_d = (delay_d == '0) ? ST_RUN : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.s_valid) begin
                        ram_wr_en  = 1'b1;
                        wr_ptr_d   = wr_ptr_q + AW'(1);
                        fill_cnt_d = fill_cnt_q + AW'(1);
                        if (fill_cnt_q == delay_q - AW'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.s_valid) begin
                        ram_wr_en = 1'b1;
                        wr_ptr_d  = wr_ptr_q + AW'(1);
                        m_valid_d = 1'b1;
                        if (delay_q == '0) begin
                            byp_d = bus.data_in;
                            src_d = OUT_BYP;
                        end else begin
                            ram_rd_en = 1'b1;
                            src_d     = OUT_RAM;
                        end
                    end
                end
                ST_FLUSH: begin
                    wr_ptr_d   = '0;
                    fill_cnt_d = '0;
                    src_d      = OUT_ZERO;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= OUT_ZERO;
            delay_q    <= '0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            byp_q      <= '0;
            m_valid_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            delay_q    <= delay_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            byp_q      <= byp_d;
            m_valid_q  <= m_valid_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // data_out is a mux of held registers: the RAM read register keeps its
    // value between reads, and src_q (reset to OUT_ZERO) forces zero
    // immediately on reset or flush.
    always_comb begin
        case (src_q)
            OUT_RAM: bus.data_out = ram_rd_data;
            OUT_BYP: bus.data_out = byp_q;
            default: bus.data_out = '0;
        endcase
    end

    assign bus.m_valid = m_valid_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.state   = state_q;
    assign bus.cfg_err = cfg_err_q;

`ifdef LNVD_DELAY_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (state_q == ST_IDLE && bus.start && !bus.stop) begin
            drop_cnt_d = '0;
        end else if (bus.s_valid && drop_cnt_q != '1 &&
                     (state_q == ST_IDLE || state_q == ST_FLUSH || bus.stop)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule : lnvd_delay_sched
`default_nettype wire

// File: tb/tb_lnvd_delay_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lnvd_delay_sched
// Description : Directed, table-driven bench for lnvd_delay_sched plus
//               hand-written sequences for clamped delay with pointer wrap,
//               asynchronous reset mid-RUN and the optional drop counter
//               (LNVD_DELAY_DROP_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lnvd_delay_sched;
    import lnvd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lnvd_delay_sched_if #(.AW(LNVD_AW), .DW(LNVD_DW)) bus ();

    lnvd_delay_sched #(.DEPTH(LNVD_DEPTH), .AW(LNVD_AW), .DW(LNVD_DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic        sv;
        logic [47:0] din;
        logic        start;
        logic        stop;
        logic        ld;
        logic [8:0]  cfgd;
        logic        mv;
        logic [47:0] dout;
        logic [1:0]  st;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic sv, input logic [47:0] din,
                                input logic start, input logic stop,
                                input logic ld, input logic [8:0] cfgd,
                                input logic mv, input logic [47:0] dout,
                                input logic [1:0] st, input logic busy,
                                input logic err);
        vec_t v;
        v.sv = sv; v.din = din; v.start = start; v.stop = stop;
        v.ld = ld; v.cfgd = cfgd; v.mv = mv; v.dout = dout;
        v.st = st; v.busy = busy; v.err = err;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic mv, input logic [47:0] dout,
                           input logic [1:0] st, input logic busy, input logic err);
        chk({tag, ".m_valid"},  64'(bus.m_valid),  64'(mv));
        chk({tag, ".data_out"}, 64'(bus.data_out), 64'(dout));
        chk({tag, ".state"},    64'(bus.state),    64'(st));
        chk({tag, ".busy"},     64'(bus.busy),     64'(busy));
        chk({tag, ".cfg_err"},  64'(bus.cfg_err),  64'(err));
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic sv, input logic [47:0] din, input logic start,
                        input logic stop, input logic ld, input logic [8:0] cfgd);
        bus.s_valid   = sv;
        bus.data_in   = din;
        bus.start     = start;
        bus.stop      = stop;
        bus.cfg_load  = ld;
        bus.cfg_delay = cfgd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 48'd0, 1'b0, 1'b0, 1'b0, 9'd0);
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.data_in = '0; bus.start = 1'b0;
        bus.stop = 1'b0; bus.cfg_load = 1'b0; bus.cfg_delay = '0;

        // ---------------- reset state ----------------
        #1;
        chk_all("reset", 1'b0, 48'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef LNVD_DELAY_DROP_CNT_EN
        chk("drop.reset", 64'(bus.drop_cnt), 64'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 48'(k + 1), 1'b0, 1'b0, 1'b0, 9'd0);
        chk("drop.five", 64'(bus.drop_cnt), 64'd5);
        chk_all("drop.idle_out", 1'b0, 48'd0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 48'd0, 1'b1, 1'b0, 1'b0, 9'd0);
        chk("drop.clear", 64'(bus.drop_cnt), 64'd0);
        step(1'b0, 48'd0, 1'b0, 1'b1, 1'b0, 9'd0);
        idle();
`endif

        // ---------------- table ----------------
        // delay 0: bypass, latency 1, data_out holds
        add(0, 48'd0, 0, 0, 1, 9'd0,  0, 48'd0, 2'd0, 0, 0);
        add(0, 48'd0, 1, 0, 0, 9'd0,  0, 48'd0, 2'd2, 1, 0);
        add(1, 48'd1, 0, 0, 0, 9'd0,  1, 48'd1, 2'd2, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 48'd0, 0, 0, 0, 9'd0, 0, 48'd1, 2'd2, 1, 0);
        add(1, 48'd2, 0, 0, 0, 9'd0,  1, 48'd2, 2'd2, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 48'd0, 0, 0, 0, 9'd0, 0, 48'd2, 2'd2, 1, 0);
        add(1, 48'd3, 0, 0, 0, 9'd0,  1, 48'd3, 2'd2, 1, 0);
        add(0, 48'd0, 0, 0, 0, 9'd0,  0, 48'd3, 2'd2, 1, 0);
        add(0, 48'd0, 0, 1, 0, 9'd0,  0, 48'd0, 2'd3, 1, 0);
        add(0, 48'd0, 0, 0, 0, 9'd0,  0, 48'd0, 2'd0, 0, 0);
        // delay 3: 10..12 fill, 13 -> 10 ... 20 -> 17
        add(0, 48'd0, 0, 0, 1, 9'd3,  0, 48'd0, 2'd0, 0, 0);
        add(0, 48'd0, 1, 0, 0, 9'd0,  0, 48'd0, 2'd1, 1, 0);
        add(1, 48'd10, 0, 0, 0, 9'd0, 0, 48'd0, 2'd1, 1, 0);
        add(1, 48'd11, 0, 0, 0, 9'd0, 0, 48'd0, 2'd1, 1, 0);
        add(1, 48'd12, 0, 0, 0, 9'd0, 0, 48'd0, 2'd2, 1, 0);
        for (int k = 13; k <= 20; k++) add(1, 48'(k), 0, 0, 0, 9'd0, 1, 48'(k - 3), 2'd2, 1, 0);
        add(0, 48'd0, 0, 0, 0, 9'd0,  0, 48'd17, 2'd2, 1, 0);
        // cfg_load in RUN rejected, delay stays 3
        add(0, 48'd0, 0, 0, 1, 9'd5,  0, 48'd17, 2'd2, 1, 1);
        add(0, 48'd0, 0, 0, 0, 9'd0,  0, 48'd17, 2'd2, 1, 0);
        add(1, 48'd21, 0, 0, 0, 9'd0, 1, 48'd18, 2'd2, 1, 0);
        // stop + start together: FLUSH then IDLE, output cleared
        add(0, 48'd0, 1, 1, 0, 9'd0,  0, 48'd0, 2'd3, 1, 0);
        add(0, 48'd0, 0, 0, 0, 9'd0,  0, 48'd0, 2'd0, 0, 0);
        // oversize delay clamped to 255 with an error pulse
        add(0, 48'd0, 0, 0, 1, 9'd300, 0, 48'd0, 2'd0, 0, 1);
        add(0, 48'd0, 0, 0, 0, 9'd0,   0, 48'd0, 2'd0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].sv, tbl[i].din, tbl[i].start, tbl[i].stop, tbl[i].ld, tbl[i].cfgd);
            chk_all($sformatf("vec%0d", i), tbl[i].mv, tbl[i].dout, tbl[i].st,
                    tbl[i].busy, tbl[i].err);
        end

        // ---------------- delay 255 across pointer wrap ----------------
        step(1'b0, 48'd0, 1'b1, 1'b0, 1'b0, 9'd0);
        chk("wrap.start_state", 64'(bus.state), 64'd1);
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 48'(1000 + k), 1'b0, 1'b0, 1'b0, 9'd0);
            if (k < 255) begin
                chk($sformatf("wrap.mv%0d", k), 64'(bus.m_valid), 64'd0);
                chk($sformatf("wrap.st%0d", k), 64'(bus.state), (k < 254) ? 64'd1 : 64'd2);
            end else begin
                chk($sformatf("wrap.mv%0d", k), 64'(bus.m_valid), 64'd1);
                chk($sformatf("wrap.dout%0d", k), 64'(bus.data_out), 64'(1000 + k - 255));
            end
        end

        // ---------------- async reset mid-RUN ----------------
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst", 1'b0, 48'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // delay register was reset to 0: start goes straight to RUN
        step(1'b0, 48'd0, 1'b1, 1'b0, 1'b0, 9'd0);
        chk("arst.delay0", 64'(bus.state), 64'd2);
        step(1'b0, 48'd0, 1'b0, 1'b1, 1'b0, 9'd0);
        idle();
        step(1'b0, 48'd0, 1'b0, 1'b0, 1'b1, 9'd2);
        step(1'b0, 48'd0, 1'b1, 1'b0, 1'b0, 9'd0);
        chk("rst2.start", 64'(bus.state), 64'd1);
        step(1'b1, 48'd50, 1'b0, 1'b0, 1'b0, 9'd0);
        chk_all("rst2.s50", 1'b0, 48'd0, 2'd1, 1'b1, 1'b0);
        step(1'b1, 48'd51, 1'b0, 1'b0, 1'b0, 9'd0);
        chk_all("rst2.s51", 1'b0, 48'd0, 2'd2, 1'b1, 1'b0);
        step(1'b1, 48'd52, 1'b0, 1'b0, 1'b0, 9'd0);
        chk_all("rst2.s52", 1'b1, 48'd50, 2'd2, 1'b1, 1'b0);
        step(1'b1, 48'd53, 1'b0, 1'b0, 1'b0, 9'd0);
        chk_all("rst2.s53", 1'b1, 48'd51, 2'd2, 1'b1, 1'b0);
        // sample coincident with stop is dropped
        step(1'b1, 48'd54, 1'b0, 1'b1, 1'b0, 9'd0);
        chk_all("rst2.stop", 1'b0, 48'd0, 2'd3, 1'b1, 1'b0);
        idle();
        chk_all("rst2.idle", 1'b0, 48'd0, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_lnvd_delay_sched
`default_nettype wire
